// File: rtl/nibble_add_seq.sv
// Multi-nibble adder sequencer: time-shares one external nibble_adder, LSB nibble first,
// chaining the carry. Optional overflow output enabled by NIBBLE_ADD_SEQ_OVF_EN.
module nibble_add_seq #(
  parameter int NIBBLES = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_s,
  input  logic                 add_cout,
  input  logic                 add_valid
`ifdef NIBBLE_ADD_SEQ_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

  state_t               state_reg, state_next;
  logic [4*NIBBLES-1:0] a_reg, b_reg, sum_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [7:0]           wait_cnt_reg;
  logic                 carry_reg, cout_reg, ovf_reg;
  logic                 last_pass;

  assign last_pass = (idx_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    add_a      = 4'd0;
    add_b      = 4'd0;
    add_cin    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = ISSUE;
      end
      ISSUE, WAIT: begin
        busy    = 1'b1;
        add_a   = a_reg[4*idx_reg +: 4];
        add_b   = b_reg[4*idx_reg +: 4];
        add_cin = carry_reg;
        // A valid seen in ISSUE may belong to the previous pass, so only WAIT looks at it.
        if (state_reg == ISSUE) begin
          state_next = WAIT;
        end else if (add_valid) begin
          state_next = last_pass ? DONE : ISSUE;
        end else if (wait_cnt_reg == WAIT_LIMIT) begin
          state_next = ERR;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        busy       = 1'b1;
        err        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      sum_reg      <= '0;
      idx_reg      <= '0;
      wait_cnt_reg <= '0;
      carry_reg    <= 1'b0;
      cout_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg        <= op_a;
            b_reg        <= op_b;
            carry_reg    <= cin;
            sum_reg      <= '0;
            idx_reg      <= '0;
            wait_cnt_reg <= '0;
            cout_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
          end
        end
        ISSUE: wait_cnt_reg <= '0;
        WAIT: begin
          if (add_valid) begin
            sum_reg[4*idx_reg +: 4] <= add_s;
            carry_reg               <= add_cout;
            if (last_pass) begin
              cout_reg <= add_cout;
              // Carry into the MSB is recovered from the sum bit and the MSB operands.
              ovf_reg  <= add_a[3] ^ add_b[3] ^ add_s[3] ^ add_cout;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        ERR: begin
          cout_reg <= 1'b0;
          ovf_reg  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

`ifdef NIBBLE_ADD_SEQ_OVF_EN
  assign ovf = ovf_reg;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed-vector bench for nibble_add_seq (NIBBLES=4, TIMEOUT=15) with a behavioural
// nibble adder whose valid line is stalled per test.
module tb_nibble_add_seq;

  logic        clk = 1'b0;
  logic        rst, start, cin;
  logic [15:0] op_a, op_b;
  logic        busy, done, err, cout;
  logic [15:0] sum;
  logic [3:0]  add_a, add_b, add_s;
  logic        add_cin, add_cout, add_valid;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural adder: result available combinationally, gated by add_valid.
  assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  nibble_add_seq #(.NIBBLES(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .err(err), .sum(sum), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout), .add_valid(add_valid)
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one operation; valid is low in cycles [stall_lo, stall_hi]; start is re-pulsed
  // with other operands in cycle spam_cyc. Cycle 0 ends at the edge that samples start.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input int stall_lo, input int stall_hi,
                        input int spam_cyc, input logic [15:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf, input int exp_cyc,
                        input logic exp_err, input logic chk_sum);
    int hit;
    int cyc;
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 1'b0);
    op_a = a; op_b = b; cin = c; start = 1'b1; add_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = -1;
    for (cyc = 1; cyc <= 60; cyc++) begin
      if (cyc == 1) begin
        check({tag, "_busy1"}, busy, 1'b1);
        check({tag, "_add_a0"}, add_a, a[3:0]);
        check({tag, "_add_b0"}, add_b, b[3:0]);
        check({tag, "_add_cin0"}, add_cin, c);
      end
      if (done || err) begin
        hit = cyc;
        break;
      end
      add_valid = !(cyc >= stall_lo && cyc <= stall_hi);
      if (cyc == spam_cyc) begin
        start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    add_valid = 1'b1;
    check({tag, "_cycle"}, hit, exp_cyc);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_done"}, done, !exp_err);
    if (chk_sum) check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, cout, exp_cout);
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    check({tag, "_ovf"}, ovf, exp_ovf);
`endif
    @(posedge clk); #1;
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_done_after"}, done, 1'b0);
    if (chk_sum) check({tag, "_sum_held"}, sum, exp_sum);
    $display("op %s a=%04h b=%04h cin=%0d -> sum=%04h cout=%0d end_cycle=%0d err=%0d",
             tag, a, b, c, sum, cout, hit, err);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_sum"}, sum, 16'h0000);
    check({tag, "_cout"}, cout, 1'b0);
    check({tag, "_add"}, {add_a, add_b, add_cin}, 9'd0);
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    check({tag, "_ovf"}, ovf, 1'b0);
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cin = 1'b0; op_a = '0; op_b = '0; add_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    //     tag       A         B        cin lo  hi   spam sum       cout ovf  cyc err chk
    run_op("basic",  16'h1234, 16'h0FFF, 0, 0,  -1,  -1, 16'h2233, 0,   0,  9,  0,  1);
    run_op("ripple", 16'hFFFF, 16'h0001, 0, 0,  -1,  -1, 16'h0000, 1,   0,  9,  0,  1);
    run_op("ovf",    16'h7FFF, 16'h0001, 0, 0,  -1,  -1, 16'h8000, 0,   1,  9,  0,  1);

    // Reset in cycle 5 of an operation, after a nonzero result is held.
    @(negedge clk);
    op_a = 16'hFFFF; op_b = 16'h0001; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midrst");
    $display("op midrst: reset applied in cycle 5, outputs cleared");
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 16'h0003, 16'h0004, 0, 0, -1, -1, 16'h0007, 0, 0, 9, 0, 1);

    // Simultaneous reset and start: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op_a = 16'h1111; op_b = 16'h1111;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check_all_zero("rst_start");
    $display("op rst_start: start with reset ignored");

    run_op("stall",  16'h00FF, 16'h0001, 1, 4,  8,    5, 16'h0101, 0,   0,  14, 0,  1);
    run_op("tmo_edge", 16'h0001, 16'h0002, 0, 2, 15, -1, 16'h0003, 0,   0,  23, 0,  1);
    run_op("timeout", 16'h1234, 16'h4321, 0, 1, 1000, -1, 16'h0000, 0,  0,  17, 1,  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Sequencer that performs a multi-nibble addition by time-sharing one external `nibble_adder`. It takes two `4*NIBBLES`-bit operands with a start/done handshake and feeds them to the adder one nibble per pass, least-significant nibble first. The carry out of each pass is chained into the carry in of the next, and the partial sums are assembled into a full-width result. It sits between a requester (CPU-side register block or a testbench driver) and the `nibble_adder` instance, and owns that adder's `a`, `b` and `cin` inputs.

## Interface
- `NIBBLES`, default 4: operand width in nibbles (W = 4*NIBBLES); legal range 1..16.
- `TIMEOUT`, default 15: maximum cycles spent waiting in WAIT for `add_valid` before aborting; legal range 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request pulse; sampled only in IDLE.
- `op_a` in W: operand A; captured on accepted `start`.
- `op_b` in W: operand B; captured on accepted `start`.
- `cin` in 1: initial carry; captured on accepted `start`.
- `busy` out 1: high from the cycle after acceptance through DONE/ERR inclusive.
- `done` out 1: one-cycle pulse; `sum`/`cout` valid.
- `err` out 1: one-cycle pulse on timeout abort.
- `sum` out W: result; held until the next accepted `start`.
- `cout` out 1: final carry; held with `sum`.
- `add_a` out 4: nibble of A sent to the adder.
- `add_b` out 4: nibble of B sent to the adder.
- `add_cin` out 1: chained carry to the adder.
- `add_s` in 4: adder sum.
- `add_cout` in 1: adder carry out.
- `add_valid` in 1: adder result valid.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE:
  - On `start`=1, register `op_a`, `op_b` and `cin`; clear nibble index `idx` and the wait counter; go to ISSUE.
  - `start` outside IDLE is ignored, with no queuing.
- ISSUE:
  - Drive `add_a`=A[4*idx+:4], `add_b`=B[4*idx+:4], `add_cin`=carry register.
  - Go to WAIT.
  - `add_valid` is ignored in this cycle, so a stale valid from the previous pass cannot be captured.
- WAIT:
  - Hold `add_a`, `add_b` and `add_cin` stable.
  - If `add_valid`=1: write `add_s` into `sum[4*idx+:4]` and `add_cout` into the carry register.
  - After that capture: if idx = NIBBLES-1, go to DONE; otherwise increment idx and go to ISSUE.
  - If `add_valid`=0: increment the wait counter.
  - When the wait counter reaches TIMEOUT, go to ERR.
- DONE: `done`=1, `cout`=carry register; go to IDLE.
- ERR:
  - `err`=1; go to IDLE.
  - `sum` holds the partially written value; `cout`=0.
- Idle adder inputs: `add_a`, `add_b` and `add_cin` are 0 in IDLE, DONE and ERR.
- Arithmetic: the result is unsigned modulo 2^W, and {cout,sum} = A + B + cin exactly.

## Timing
- Reset:
  - `rst`=1 forces IDLE at the next edge, from any state, including mid-operation.
  - All outputs are 0 during and after reset: `busy`, `done`, `err`, `sum`, `cout`, `add_*`.
  - The pending operation is discarded.
- Numbering: the edge that samples `start` ends cycle 0.
  - ISSUE for nibble k occupies cycle 2k+1.
  - With `add_valid` already high, WAIT for nibble k occupies cycle 2k+2.
  - `done` is high in cycle 2*NIBBLES+1; for NIBBLES=4 that is cycle 9.
- Each cycle of `add_valid`=0 in WAIT adds one cycle of latency.
- `busy` is high from cycle 1 through the DONE/ERR cycle. A `start` presented in the cycle after DONE is accepted.
- Timeout: `err` pulses after exactly TIMEOUT consecutive low-valid WAIT cycles in a single pass. The counter clears on every ISSUE.
- Simultaneous `rst` and `start`: reset wins.

## Configuration
- `NIBBLE_ADD_SEQ_OVF_EN`:
  - When defined, adds output port `ovf` (1 bit): the two's-complement overflow of the final pass, i.e. carry into MSB xor carry out of MSB.
  - That carry into MSB is recomputed as `add_a[3]^add_b[3]^add_s[3]` at the last capture.
  - `ovf` is valid and held with `sum`; it is 0 on reset and after ERR.
- When undefined, the port and its logic are absent.

## Test plan
- W=16, A=0x1234, B=0x0FFF, cin=0, adder valid every WAIT cycle -> `done` in cycle 9, `sum`=0x2233, `cout`=0.
- A=0xFFFF, B=0x0001, cin=0 -> carry ripples through all 4 passes; `sum`=0x0000, `cout`=1. With the macro defined, `ovf`=0.
- A=0x7FFF, B=0x0001, cin=0, macro defined -> `sum`=0x8000, `cout`=0, `ovf`=1.
- A=0x00FF, B=0x0001, cin=1, `add_valid` held low 5 cycles in pass 1 -> `sum`=0x0101, `done` in cycle 14, `start` pulses during `busy` ignored.
- `add_valid` never asserted, TIMEOUT=15 -> `err` pulse in cycle 17, `busy` low in cycle 18, `done` never high.
- `rst` asserted in cycle 5 of an operation -> all outputs 0 next cycle. A new `start` afterwards computes 0x0003+0x0004 = 0x0007 correctly, with no residual carry.
